// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - divider operand/result stream bundle between execute stage and div_iter
interface div_iter_if #(
    parameter int DATA_WD = 32
);
    logic [DATA_WD-1:0]   s_axis_dividend_tdata;
    logic                 s_axis_dividend_tvalid;
    logic                 s_axis_dividend_tready;
    logic [DATA_WD-1:0]   s_axis_divisor_tdata;
    logic                 s_axis_divisor_tvalid;
    logic                 s_axis_divisor_tready;
    logic [2*DATA_WD-1:0] m_axis_dout_tdata;
    logic                 m_axis_dout_tvalid;

    modport master (
        output s_axis_dividend_tdata, s_axis_dividend_tvalid,
        input  s_axis_dividend_tready,
        output s_axis_divisor_tdata, s_axis_divisor_tvalid,
        input  s_axis_divisor_tready,
        input  m_axis_dout_tdata, m_axis_dout_tvalid
    );

    modport slave (
        input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
        output s_axis_dividend_tready,
        input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
        output s_axis_divisor_tready,
        output m_axis_dout_tdata, m_axis_dout_tvalid
    );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multi-cycle radix-2 restoring divider with independent operand channels
module div_iter #(
    parameter int DATA_WD = 32,
    parameter int SIGNED  = 1
) (
    input  logic       clk,
    input  logic       resetn,
    div_iter_if.slave  dif
);
    localparam int CNT_WD = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic                 cap_dvd;
    logic                 cap_dvs;
    logic [DATA_WD-1:0]   dvd_hold;
    logic [DATA_WD-1:0]   dvs_hold;
    logic [DATA_WD-1:0]   quo;
    logic [DATA_WD-1:0]   dvs_mag;
    logic [DATA_WD:0]     rem;
    logic [CNT_WD-1:0]    cnt;
    logic                 neg_q;
    logic                 neg_r;
    logic [2*DATA_WD-1:0] dout_tdata;
    logic                 dout_tvalid;

    logic                 dvd_tready;
    logic                 dvs_tready;
    logic                 dvd_fire;
    logic                 dvs_fire;
    logic                 start;
    logic [DATA_WD-1:0]   dvd_op;
    logic [DATA_WD-1:0]   dvs_op;
    logic                 sgn_dvd;
    logic                 sgn_dvs;
    logic [DATA_WD-1:0]   mag_dvd;
    logic [DATA_WD-1:0]   mag_dvs;
    logic [DATA_WD:0]     rem_sh;
    logic                 ge;
    logic [DATA_WD:0]     rem_nx;
    logic [DATA_WD-1:0]   quo_nx;
    logic                 last;
    logic [DATA_WD-1:0]   q_fin;
    logic [DATA_WD-1:0]   r_fin;

    assign dvd_tready = (state == IDLE) && !cap_dvd;
    assign dvs_tready = (state == IDLE) && !cap_dvs;
    assign dvd_fire   = dif.s_axis_dividend_tvalid && dvd_tready;
    assign dvs_fire   = dif.s_axis_divisor_tvalid && dvs_tready;
    assign start      = (state == IDLE) && (cap_dvd || dvd_fire) && (cap_dvs || dvs_fire);

    // An operand arriving on the start edge itself is taken straight from the bus.
    assign dvd_op  = cap_dvd ? dvd_hold : dif.s_axis_dividend_tdata;
    assign dvs_op  = cap_dvs ? dvs_hold : dif.s_axis_divisor_tdata;
    assign sgn_dvd = (SIGNED != 0) && dvd_op[DATA_WD-1];
    assign sgn_dvs = (SIGNED != 0) && dvs_op[DATA_WD-1];
    assign mag_dvd = sgn_dvd ? -dvd_op : dvd_op;
    assign mag_dvs = sgn_dvs ? -dvs_op : dvs_op;

    // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
    assign rem_sh = {rem[DATA_WD-1:0], quo[DATA_WD-1]};
    assign ge     = rem_sh >= {1'b0, dvs_mag};
    assign rem_nx = ge ? (rem_sh - {1'b0, dvs_mag}) : rem_sh;
    assign quo_nx = {quo[DATA_WD-2:0], ge};
    assign last   = (cnt == CNT_WD'(DATA_WD - 1));
    assign q_fin  = neg_q ? -quo_nx : quo_nx;
    assign r_fin  = neg_r ? -rem_nx[DATA_WD-1:0] : rem_nx[DATA_WD-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cap_dvd     <= 1'b0;
            cap_dvs     <= 1'b0;
            dvd_hold    <= '0;
            dvs_hold    <= '0;
            quo         <= '0;
            dvs_mag     <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dout_tdata  <= '0;
            dout_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout_tvalid <= 1'b0;
                    if (start) begin
                        quo     <= mag_dvd;
                        dvs_mag <= mag_dvs;
                        rem     <= '0;
                        cnt     <= '0;
                        neg_q   <= sgn_dvd ^ sgn_dvs;
                        neg_r   <= sgn_dvd;
                        cap_dvd <= 1'b0;
                        cap_dvs <= 1'b0;
                        state   <= CALC;
                    end else begin
                        if (dvd_fire) begin
                            cap_dvd  <= 1'b1;
                            dvd_hold <= dif.s_axis_dividend_tdata;
                        end
                        if (dvs_fire) begin
                            cap_dvs  <= 1'b1;
                            dvs_hold <= dif.s_axis_divisor_tdata;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CNT_WD'(1);
                    if (last) begin
                        dout_tdata  <= {q_fin, r_fin};
                        dout_tvalid <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    dout_tvalid <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    dout_tvalid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign dif.s_axis_dividend_tready = dvd_tready;
    assign dif.s_axis_divisor_tready  = dvs_tready;
    assign dif.m_axis_dout_tdata      = dout_tdata;
    assign dif.m_axis_dout_tvalid     = dout_tvalid;
endmodule
